// File: rtl/counter_pkg.sv
// Shared types, limits and the pure next-value function for the up/down counters.
package counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_t;

  // Widest supported counter; N+1 internal bits must fit in cnt_wide_t.
  localparam int unsigned CNT_MAX_N       = 31;
  localparam int unsigned CNT_MIN_MODULUS = 2;

  typedef logic [CNT_MAX_N:0] cnt_wide_t;

  localparam cnt_wide_t CNT_ONE  = cnt_wide_t'(1);
  localparam cnt_wide_t CNT_ZERO = cnt_wide_t'(0);

  // Legal iff 1 <= n <= CNT_MAX_N, 2 <= modulus <= 2**n and reset_val < modulus.
  function automatic bit cnt_params_ok(input int unsigned n,
                                       input int unsigned modulus,
                                       input int unsigned reset_val);
    bit ok;
    ok = 1'b1;
    if (n < 1 || n > CNT_MAX_N)                   ok = 1'b0;
    else if (modulus < CNT_MIN_MODULUS)           ok = 1'b0;
    else if (modulus > (32'd1 << n))              ok = 1'b0;
    else if (reset_val >= modulus)                ok = 1'b0;
    return ok;
  endfunction

  function automatic cnt_wide_t cnt_next(input cnt_wide_t q,
                                         input cnt_dir_t  dir,
                                         input cnt_wide_t modulus);
    cnt_wide_t nxt;
    if (dir == CNT_UP) begin
      nxt = (q == modulus - CNT_ONE) ? CNT_ZERO : q + CNT_ONE;
    end else begin
      nxt = (q == CNT_ZERO) ? modulus - CNT_ONE : q - CNT_ONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo counter with enable, parallel load and tc/wrap/load_err flags.
// Define SYNC_UPDOWN_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MODULUS   = 32'd1 << N,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         wrap,
  output logic         load_err
);

  localparam int unsigned W = N + 1;

  if (!cnt_params_ok(N, MODULUS, RESET_VAL)) begin : g_bad_params
    $fatal(1, "sync_updown_counter: illegal N/MODULUS/RESET_VAL");
  end

  // N+1 bits so that MODULUS == 2**N is still representable and compares exactly.
  localparam logic [W-1:0] MOD_W   = W'(MODULUS);
  localparam logic [W-1:0] MOD_M1  = W'(MODULUS - 1);
  localparam logic [N-1:0] RESET_Q = N'(RESET_VAL);

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] q_ext;
  logic [W-1:0] load_ext;
  logic         at_top;
  logic         at_bot;
  cnt_dir_t     dir;
  cnt_wide_t    step_wide;
  logic         unused_step_hi;

  assign q_ext    = {1'b0, q_q};
  assign load_ext = {1'b0, load_val};
  assign at_top   = (q_ext == MOD_M1);
  assign at_bot   = (q_ext == '0);
  assign dir      = up_dn ? CNT_UP : CNT_DOWN;

  assign step_wide      = cnt_next(cnt_wide_t'(q_ext), dir, cnt_wide_t'(MOD_W));
  assign unused_step_hi = |step_wide[CNT_MAX_N:N];

  // Zero-latency terminal count; doubles as the cascade enable for the next stage.
  assign tc = en & ((up_dn & at_top) | (~up_dn & at_bot));

  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ext < MOD_W) begin
        q_d = load_val;
      end else begin
        q_d        = MOD_M1[N-1:0];
        load_err_d = 1'b1;
      end
    end else if (en) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
      // At the boundary in the current direction the count sticks.
      if (!tc) begin
        q_d = step_wide[N-1:0];
      end
`else
      q_d    = step_wide[N-1:0];
      wrap_d = tc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q        <= RESET_Q;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: MODULUS=10 instance plus a full-range MODULUS=16 instance.
module tb_sync_updown_counter;

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MODULUS=10 instance
  logic       reset_n  = 1'b0;
  logic       en       = 1'b0;
  logic       up_dn    = 1'b1;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q;
  logic       tc, wrap, load_err;

  // MODULUS=16 instance
  logic       b_reset_n  = 1'b0;
  logic       b_en       = 1'b0;
  logic       b_up_dn    = 1'b1;
  logic       b_load     = 1'b0;
  logic [3:0] b_load_val = 4'd0;
  logic [3:0] b_q;
  logic       b_tc, b_wrap, b_load_err;

  sync_updown_counter #(.N(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  sync_updown_counter #(.N(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk(clk), .reset_n(b_reset_n), .en(b_en), .up_dn(b_up_dn), .load(b_load),
    .load_val(b_load_val), .Q(b_q), .tc(b_tc), .wrap(b_wrap), .load_err(b_load_err)
  );

  // Scoreboard counters and the checking task
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int exp_q, input bit exp_tc,
                           input bit exp_wrap, input bit exp_err);
    check_eq({tag, ".q"},        32'(q),        32'(exp_q));
    check_eq({tag, ".tc"},       32'(tc),       32'(exp_tc));
    check_eq({tag, ".wrap"},     32'(wrap),     32'(exp_wrap));
    check_eq({tag, ".load_err"}, 32'(load_err), 32'(exp_err));
  endtask

  task automatic check_b(input string tag, input int exp_q, input bit exp_tc,
                         input bit exp_wrap, input bit exp_err);
    check_eq({tag, ".q"},        32'(b_q),        32'(exp_q));
    check_eq({tag, ".tc"},       32'(b_tc),       32'(exp_tc));
    check_eq({tag, ".wrap"},     32'(b_wrap),     32'(exp_wrap));
    check_eq({tag, ".load_err"}, 32'(b_load_err), 32'(exp_err));
  endtask

  // Driver: advance one edge, sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up_wrap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_up_sat  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};

  initial begin
    // Reset dominates load and en; nothing moves between edges
    reset_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5; up_dn = 1'b1;
    tick();
    check_all("rst1", 0, 1'b0, 1'b0, 1'b0);
    load_val = 4'd9;
    #3;
    check_eq("rst_between_edges.q", 32'(q), 32'd0);
    tick();
    check_all("rst2", 0, 1'b0, 1'b0, 1'b0);

    // Count up 12 edges from 0
    reset_n = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int e;
      e = SAT ? exp_up_sat[i] : exp_up_wrap[i];
      tick();
      check_all($sformatf("up%0d", i), e, (e == 9), (!SAT && e == 0), 1'b0);
    end

    // Load 1 with en low, then count down from 1
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    tick();
    check_all("ld1", 1, 1'b0, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    check_all("dn0", 0, 1'b1, 1'b0, 1'b0);
    // Direction flip at the boundary flips tc immediately
    up_dn = 1'b1;
    #1;
    check_eq("flip_up.tc", 32'(tc), 32'd0);
    up_dn = 1'b0;
    #1;
    check_eq("flip_dn.tc", 32'(tc), 32'd1);
    tick();
    if (SAT) check_all("dn1", 0, 1'b1, 1'b0, 1'b0);
    else     check_all("dn1", 9, 1'b0, 1'b1, 1'b0);
    tick();
    if (SAT) check_all("dn2", 0, 1'b1, 1'b0, 1'b0);
    else     check_all("dn2", 8, 1'b0, 1'b0, 1'b0);

    // Hold
    en = 1'b0;
    tick();
    check_all("hold", SAT ? 0 : 8, 1'b0, 1'b0, 1'b0);

    // Load beats en; out-of-range load clamps and flags for one cycle
    load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 4'd7;
    tick();
    check_all("ld7", 7, 1'b0, 1'b0, 1'b0);
    load_val = 4'd12;
    tick();
    check_all("ld12", 9, 1'b1, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    tick();
    check_all("ld12_after", 9, 1'b0, 1'b0, 1'b0);

    // Load at the terminal count: no wrap pulse
    en = 1'b1; load = 1'b1; load_val = 4'd3;
    #1;
    check_eq("pre_ld3.tc", 32'(tc), 32'd1);
    tick();
    check_all("ld3", 3, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    check_all("up_from3", 4, 1'b0, 1'b0, 1'b0);

    // Mid-count reset, then resume from RESET_VAL
    reset_n = 1'b0;
    tick();
    check_all("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    check_all("resume", 1, 1'b0, 1'b0, 1'b0);

    // Load boundaries: MODULUS-1 legal, MODULUS illegal
    load = 1'b1; load_val = 4'd9;
    tick();
    check_all("ld9", 9, 1'b1, 1'b0, 1'b0);
    load_val = 4'd10;
    tick();
    check_all("ld10", 9, 1'b1, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    tick();
    check_all("ld10_after", 9, 1'b0, 1'b0, 1'b0);

    // Full-range instance: 15 -> 0 must wrap exactly
    b_reset_n = 1'b1; b_load = 1'b1; b_load_val = 4'd15; b_en = 1'b1; b_up_dn = 1'b1;
    tick();
    check_b("b_ld15", 15, 1'b1, 1'b0, 1'b0);
    b_load = 1'b0;
    tick();
    if (SAT) check_b("b_up", 15, 1'b1, 1'b0, 1'b0);
    else     check_b("b_up", 0,  1'b0, 1'b1, 1'b0);
    b_up_dn = 1'b0;
    #1;
    check_eq("b_dir.tc", 32'(b_tc), SAT ? 32'd0 : 32'd1);
    tick();
    if (SAT) check_b("b_dn", 14, 1'b0, 1'b0, 1'b0);
    else     check_b("b_dn", 15, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
